rvm_mem_arbiter: RTL and testbench
==================================

# rvm_mem_arbiter

Sequencer and arbiter for the core's single memory port, sharing it between the instruction-fetch requester and the load/store requester inside `rvm_core`. It accepts one request at a time from either side, drives the `mem_*` bus for the duration of the access (including stalls), and returns registered read data and error status to the winning requester. Alternating priority prevents starvation. An optional watchdog aborts accesses that stall indefinitely.

## Interface
Parameters:
- `TIMEOUT`, 255: stall cycles tolerated before abort; legal range 1..255; used only with `RVM_MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `f_req` in 1: fetch request; held high, with `f_addr` stable, until `f_rsp_valid`.
- `f_addr` in 32: fetch address.
- `f_rsp_valid` out 1: one-cycle pulse; fetch access complete.
- `f_rdata` out 32: fetched word; valid with `f_rsp_valid`.
- `f_error` out 1: fetch access faulted; valid with `f_rsp_valid`.
- `d_req` in 1: load/store request; same hold rule as `f_req`.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_b_en` in 4: byte enables; `4'b0000` is a load, any other value is a store.
- `d_rsp_valid` out 1: one-cycle pulse; data access complete.
- `d_rdata` out 32: load data; valid with `d_rsp_valid`.
- `d_error` out 1: data access faulted; valid with `d_rsp_valid`.
- `mem_addr` out 32: memory address.
- `mem_rdata` in 32: memory read data.
- `mem_wdata` out 32: memory write data.
- `mem_c_en` out 1: memory chip enable.
- `mem_b_en` out 4: byte enables (`0000` is a read).
- `mem_error` in 1: memory error; sampled on completion.
- `mem_stall` in 1: memory stall.
- `busy` out 1: high while in ACCESS.

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE:**
  - `mem_c_en` = 0.
  - Eligible requester: `x_req` = 1 and `x_rsp_valid` = 0 in the same cycle. This masks the stale request in the cycle a response is delivered.
  - One eligible requester: grant it.
  - Both eligible: grant the one not granted last. `last_grant` resets to fetch, so data wins the first tie.
  - On grant: latch address, wdata, b_en and owner, then go to ACCESS.
  - Fetch latches `wdata` = 0 and `b_en` = `4'b0000`.
- **ACCESS:**
  - `mem_c_en` = 1; `mem_addr`, `mem_wdata`, `mem_b_en` are driven from the latched registers.
  - `mem_stall` = 1: remain in ACCESS with all bus outputs held.
  - `mem_stall` = 0: the access completes this cycle. Capture `mem_rdata` (forced to 0 for a store) and `mem_error` into the owner's response registers, assert the owner's `rsp_valid` next cycle, update `last_grant`, and return to IDLE.
- Response data and error registers hold their values until the next response to the same requester.
- The non-owner's `rsp_valid` is always 0.
- **Reset:**
  - State goes to IDLE; `last_grant` = fetch.
  - All outputs go to 0: `mem_c_en`, `mem_b_en`, `mem_addr`, `mem_wdata`, both `rsp_valid`, rdata, error, and `busy`.
  - An access in flight is abandoned and no response is issued.

## Timing
- Request seen at edge N (IDLE, eligible) → `mem_c_en` = 1 in cycle N+1.
- With no stall, completion is at edge N+1 and `rsp_valid` is high in cycle N+2 (latency 2).
- Each stall cycle adds one cycle.
- The next grant is evaluated in cycle N+2 (IDLE), so `mem_c_en` is next high in cycle N+3.
- Peak throughput: one access per 2 cycles; `mem_c_en` is low for at least 1 cycle between accesses.
- Requester behaviour:
  - Sample `rsp_valid` and drop `req` in that same cycle.
  - A `req` still high in the cycle after `rsp_valid` is treated as a new request.
- A simultaneous new `f_req` during a data access is not granted until IDLE.
- Dropping `req` before `rsp_valid` is illegal; the latched access completes regardless.

## Configuration
- **`RVM_MEM_ARB_TIMEOUT_EN` defined:**
  - An 8-bit stall counter clears on entry to ACCESS and increments in each ACCESS cycle with `mem_stall` = 1.
  - When the counter equals `TIMEOUT` while still stalled, the access is aborted: go to IDLE and pulse the owner's `rsp_valid` with error = 1 and rdata = 0 next cycle.
  - `mem_c_en` drops in the abort response cycle.
- **Not defined:**
  - No counter; an ACCESS can stall forever.
  - `TIMEOUT` is ignored.

## Test plan
- **Single fetch:** `f_req` with `f_addr` = 0x100, `mem_rdata` = 0xDEADBEEF, no stall → `mem_c_en` cycle 1 with `mem_b_en` = 0000; `f_rsp_valid` cycle 2 with `f_rdata` = 0xDEADBEEF, `f_error` = 0.
- **Store with stall:** `d_req`, `d_addr` = 0x2004, `d_wdata` = 0x12345678, `d_b_en` = 0011, 3 stall cycles → `mem_c_en` held 4 cycles with stable bus; `d_rsp_valid` 5 cycles after request, `d_rdata` = 0.
- **Contention:** `f_req` and `d_req` both held continuously → grants alternate data, fetch, data, fetch. Each response is 2 cycles after its grant.
- **Error and reset:**
  - `mem_error` = 1 on completion of a load → `d_error` = 1.
  - `reset` asserted in a stalled ACCESS → next cycle `mem_c_en` = 0, `busy` = 0, and no `rsp_valid` ever issued.
- **Timeout:** with the macro defined, `TIMEOUT` = 4 and `mem_stall` stuck high → abort and `f_rsp_valid` with `f_error` = 1, `f_rdata` = 0. Without the macro, `busy` remains high for 1000 cycles.

Source files
------------

// File: rtl/rvm_mem_arbiter.sv
// Two-requester (fetch / load-store) sequencer for the core's single memory port.
// Optional stall watchdog is enabled by defining RVM_MEM_ARB_TIMEOUT_EN.
module rvm_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_rsp_valid,
  output logic [31:0] f_rdata,
  output logic        f_error,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_b_en,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic [3:0]  mem_b_en,
  input  logic        mem_error,
  input  logic        mem_stall,
  output logic        busy,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e      state_q;
  logic        last_grant_q;  // 0 = fetch, 1 = data
  logic        owner_q;
  logic [31:0] mem_addr_q, mem_wdata_q, f_rdata_q, d_rdata_q;
  logic [3:0]  mem_b_en_q;
  logic        mem_c_en_q, busy_q;
  logic        f_rsp_valid_q, d_rsp_valid_q, f_error_q, d_error_q;

  logic        f_elig_d, d_elig_d, grant_data_d;
  logic        fin_d, fin_err_d;
  logic [31:0] fin_rdata_d;

`ifdef RVM_MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0] stall_cnt_q;
`endif

  // A requester whose response is on the wire this cycle is still holding a stale req.
  always_comb begin
    f_elig_d     = f_req && !f_rsp_valid_q;
    d_elig_d     = d_req && !d_rsp_valid_q;
    grant_data_d = d_elig_d && (!f_elig_d || !last_grant_q);
    fin_d        = 1'b0;
    fin_err_d    = 1'b0;
    fin_rdata_d  = '0;
    if (state_q == ACCESS) begin
      if (!mem_stall) begin
        fin_d       = 1'b1;
        fin_err_d   = mem_error;
        fin_rdata_d = (mem_b_en_q != 4'b0000) ? 32'h0 : mem_rdata;
      end
`ifdef RVM_MEM_ARB_TIMEOUT_EN
      else if (stall_cnt_q == TIMEOUT_C) begin
        fin_d     = 1'b1;
        fin_err_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b0;
      owner_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_b_en_q    <= '0;
      mem_c_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      f_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      f_rdata_q     <= '0;
      d_rdata_q     <= '0;
      f_error_q     <= 1'b0;
      d_error_q     <= 1'b0;
`ifdef RVM_MEM_ARB_TIMEOUT_EN
      stall_cnt_q   <= '0;
`endif
    end else begin
      f_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (f_elig_d || d_elig_d) begin
            owner_q     <= grant_data_d;
            mem_addr_q  <= grant_data_d ? d_addr : f_addr;
            mem_wdata_q <= grant_data_d ? d_wdata : 32'h0;
            mem_b_en_q  <= grant_data_d ? d_b_en : 4'b0000;
            mem_c_en_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
`ifdef RVM_MEM_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
          end
        end
        ACCESS: begin
          if (fin_d) begin
            state_q      <= IDLE;
            mem_c_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= owner_q;
            if (owner_q) begin
              d_rsp_valid_q <= 1'b1;
              d_rdata_q     <= fin_rdata_d;
              d_error_q     <= fin_err_d;
            end else begin
              f_rsp_valid_q <= 1'b1;
              f_rdata_q     <= fin_rdata_d;
              f_error_q     <= fin_err_d;
            end
          end
`ifdef RVM_MEM_ARB_TIMEOUT_EN
          else begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f_rsp_valid = f_rsp_valid_q;
  assign f_rdata     = f_rdata_q;
  assign f_error     = f_error_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rdata     = d_rdata_q;
  assign d_error     = d_error_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_b_en    = mem_b_en_q;
  assign mem_c_en    = mem_c_en_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Directed self-checking bench for rvm_mem_arbiter (default build and RVM_MEM_ARB_TIMEOUT_EN build).
module tb_rvm_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, mem_error, mem_stall;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_b_en;
  logic        f_rsp_valid, f_error, d_rsp_valid, d_error, mem_c_en, busy, dbg_state;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_b_en;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  rvm_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rsp_valid(f_rsp_valid), .f_rdata(f_rdata), .f_error(f_error),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_b_en(d_b_en),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_error(d_error),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en),
    .mem_b_en(mem_b_en), .mem_error(mem_error), .mem_stall(mem_stall), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // advance one cycle; outputs are sampled and inputs driven 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] want;
    logic        seen;
    logic        busy_ok;

    reset = 1'b1; f_req = 0; d_req = 0; f_addr = 0; d_addr = 0; d_wdata = 0; d_b_en = 0;
    mem_rdata = 0; mem_error = 0; mem_stall = 0;
    step(); step(); step();
    chk("rst_cen",  {31'h0, mem_c_en}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rsp",  {30'h0, f_rsp_valid, d_rsp_valid}, 0);
    reset = 1'b0;
    step();

    // single fetch
    f_req = 1; f_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    step();
    chk("f1_cen",  {31'h0, mem_c_en}, 1);
    chk("f1_addr", mem_addr, 32'h100);
    chk("f1_ben",  {28'h0, mem_b_en}, 0);
    chk("f1_busy", {31'h0, busy}, 1);
    step();
    chk("f1_vld",   {31'h0, f_rsp_valid}, 1);
    chk("f1_dvld",  {31'h0, d_rsp_valid}, 0);
    chk("f1_rdata", f_rdata, 32'hDEADBEEF);
    chk("f1_err",   {31'h0, f_error}, 0);
    chk("f1_cen0",  {31'h0, mem_c_en}, 0);
    f_req = 0;
    step();

    // contention: last grant is fetch, so data goes first
    f_addr = 32'h40; d_addr = 32'h80; d_b_en = 4'b0000; mem_rdata = 32'h11112222;
    f_req = 1; d_req = 1;
    exp_q.push_back(32'h80); exp_q.push_back(32'h40);
    exp_q.push_back(32'h80); exp_q.push_back(32'h40);
    for (int g = 0; g < 4; g++) begin
      step();
      want = exp_q.pop_front();
      chk("ctn_cen",  {31'h0, mem_c_en}, 1);
      chk("ctn_addr", mem_addr, want);
      step();
      chk("ctn_dvld", {31'h0, d_rsp_valid}, (want == 32'h80) ? 1 : 0);
      chk("ctn_fvld", {31'h0, f_rsp_valid}, (want == 32'h40) ? 1 : 0);
      chk("ctn_gap",  {31'h0, mem_c_en}, 0);
      if (g == 3) begin
        f_req = 0; d_req = 0;
      end
    end
    step();

    // store with three stall cycles
    d_req = 1; d_addr = 32'h2004; d_wdata = 32'h12345678; d_b_en = 4'b0011;
    mem_stall = 1; mem_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_cen",   {31'h0, mem_c_en}, 1);
      chk("st_addr",  mem_addr, 32'h2004);
      chk("st_wdata", mem_wdata, 32'h12345678);
      chk("st_ben",   {28'h0, mem_b_en}, 32'h3);
      chk("st_novld", {31'h0, d_rsp_valid}, 0);
      if (i == 3) mem_stall = 0;
    end
    step();
    chk("st_vld",   {31'h0, d_rsp_valid}, 1);
    chk("st_rdata", d_rdata, 0);
    chk("st_err",   {31'h0, d_error}, 0);
    d_req = 0;
    step();

    // load with memory error
    d_req = 1; d_addr = 32'h300; d_b_en = 4'b0000; mem_rdata = 32'hCAFEF00D; mem_error = 1;
    step();
    chk("le_ben", {28'h0, mem_b_en}, 0);
    step();
    chk("le_vld",   {31'h0, d_rsp_valid}, 1);
    chk("le_err",   {31'h0, d_error}, 1);
    chk("le_rdata", d_rdata, 32'hCAFEF00D);
    chk("le_frd",   f_rdata, 32'h11112222);
    d_req = 0; mem_error = 0;
    step();

    // reset while stalled
    f_req = 1; f_addr = 32'h500; mem_stall = 1;
    step();
    chk("rs_busy1", {31'h0, busy}, 1);
    step();
    reset = 1; f_req = 0;
    step();
    chk("rs_cen",  {31'h0, mem_c_en}, 0);
    chk("rs_busy", {31'h0, busy}, 0);
    reset = 0; mem_stall = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rs_norsp", {30'h0, f_rsp_valid, d_rsp_valid}, 0);
    end

    // stall stuck high
    f_req = 1; f_addr = 32'h600; mem_stall = 1; mem_rdata = 32'h77;
`ifdef RVM_MEM_ARB_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (f_rsp_valid) seen = 1;
    end
    chk("to_seen",  {31'h0, seen}, 1);
    chk("to_err",   {31'h0, f_error}, 1);
    chk("to_rdata", f_rdata, 0);
    chk("to_cen",   {31'h0, mem_c_en}, 0);
    f_req = 0; mem_stall = 0;
    step();
`else
    busy_ok = 1;
    seen = 0;
    step();
    for (int i = 0; i < 1000; i++) begin
      if (!busy) busy_ok = 0;
      if (f_rsp_valid) seen = 1;
      step();
    end
    chk("to_busy",  {31'h0, busy_ok}, 1);
    chk("to_norsp", {31'h0, seen}, 0);
    reset = 1; f_req = 0; mem_stall = 0;
    step();
    reset = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
